// File: rtl/pwm_pkg.sv
// Shared widths, timing constants and state encoding for the PWM position sequencer.
package pwm_pkg;

   localparam int unsigned POS_W         = 10;
   localparam int unsigned PERIOD_CYCLES = 1 << POS_W;
   localparam int unsigned HOLD_PERIODS  = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RAMP   = 2'd1,
      SETTLE = 2'd2
   } state_t;

endpackage

// File: rtl/pwm_position_sequencer_if.sv
// Command handshake between a position source (master) and the sequencer (slave).
interface pwm_position_sequencer_if #(
   parameter int unsigned POS_W = pwm_pkg::POS_W
);

   logic             cmd_valid;
   logic             cmd_ready;
   logic [POS_W-1:0] cmd_pos;
   logic [POS_W-1:0] cmd_step;
   logic             cmd_abort;

   modport master (
      output cmd_valid,
      output cmd_pos,
      output cmd_step,
      output cmd_abort,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_pos,
      input  cmd_step,
      input  cmd_abort,
      output cmd_ready
   );

endinterface

// File: rtl/pwm_period_timer.sv
// Free-running PWM period counter; boundary_c marks the last cycle of a period and
// period_start pulses in the first cycle of the next. Shareable with the PWM generator.
module pwm_period_timer #(
   parameter int unsigned POS_W = pwm_pkg::POS_W
) (
   input  logic CLK,
   input  logic reset,
   output logic boundary_c,
   output logic period_start
);

   logic [POS_W-1:0] cnt;

   // Last count value of the period (2^POS_W - 1)
   assign boundary_c = (cnt == '1);

   // Counter wraps naturally; period_start follows the boundary by one edge
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         cnt          <= '0;
         period_start <= 1'b0;
      end else begin
         cnt          <= cnt + POS_W'(1);
         period_start <= boundary_c;
      end
   end

endmodule

// File: rtl/pwm_position_sequencer.sv
// Sequences target positions into the PWM generator's Position input, ramping by a
// programmable step only at period boundaries, then holding before signalling done.
module pwm_position_sequencer #(
   parameter int unsigned POS_W        = pwm_pkg::POS_W,
   parameter int unsigned HOLD_PERIODS = pwm_pkg::HOLD_PERIODS
) (
   input  logic                    CLK,
   input  logic                    reset,
   pwm_position_sequencer_if.slave cmd,
   output logic [POS_W-1:0]        pos_out,
   output logic                    period_start,
   output logic                    busy,
   output logic                    done
);

   import pwm_pkg::*;

   localparam int unsigned HOLD_W = $clog2(HOLD_PERIODS + 1);

   state_t            state_q;
   state_t            state_d;
   logic [POS_W-1:0]  target_q;
   logic [POS_W-1:0]  target_d;
   logic [POS_W-1:0]  step_q;
   logic [POS_W-1:0]  step_d;
   logic [POS_W-1:0]  pos_d;
   logic [HOLD_W-1:0] hold_q;
   logic [HOLD_W-1:0] hold_d;
   logic              done_d;
   logic              boundary_c;
   logic [POS_W-1:0]  gap_c;
   logic [POS_W-1:0]  delta_c;
   logic [POS_W-1:0]  ramp_pos_c;

   pwm_period_timer #(
      .POS_W (POS_W)
   ) u_timer (
      .CLK          (CLK),
      .reset        (reset),
      .boundary_c   (boundary_c),
      .period_start (period_start)
   );

   // Next ramp position: step clamped to the remaining gap, so it can never overshoot or wrap
   always_comb begin
      gap_c      = (target_q >= pos_out) ? (target_q - pos_out) : (pos_out - target_q);
      delta_c    = (step_q < gap_c) ? step_q : gap_c;
      ramp_pos_c = (target_q >= pos_out) ? (pos_out + delta_c) : (pos_out - delta_c);
   end

   // Next-state and next-output logic; abort takes priority over a coincident boundary
   always_comb begin
      state_d  = state_q;
      pos_d    = pos_out;
      target_d = target_q;
      step_d   = step_q;
      hold_d   = hold_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cmd.cmd_valid && cmd.cmd_ready) begin
               target_d = cmd.cmd_pos;
               step_d   = (cmd.cmd_step == '0) ? POS_W'(1) : cmd.cmd_step;
               state_d  = RAMP;
            end
         end
         RAMP: begin
            if (cmd.cmd_abort) begin
               state_d = IDLE;
            end else if (boundary_c) begin
               pos_d = ramp_pos_c;
               if (ramp_pos_c == target_q) begin
                  state_d = SETTLE;
                  hold_d  = '0;
               end
            end
         end
         SETTLE: begin
            if (cmd.cmd_abort) begin
               state_d = IDLE;
            end else if (boundary_c) begin
               if (hold_q == HOLD_W'(HOLD_PERIODS - 1)) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; ready/busy track the upcoming state
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         pos_out       <= '0;
         target_q      <= '0;
         step_q        <= POS_W'(1);
         hold_q        <= '0;
         done          <= 1'b0;
         busy          <= 1'b0;
         cmd.cmd_ready <= 1'b1;
      end else begin
         state_q       <= state_d;
         pos_out       <= pos_d;
         target_q      <= target_d;
         step_q        <= step_d;
         hold_q        <= hold_d;
         done          <= done_d;
         busy          <= (state_d != IDLE);
         cmd.cmd_ready <= (state_d == IDLE);
      end
   end

endmodule

// File: tb/tb_pwm_position_sequencer.sv
// Self-checking bench for pwm_position_sequencer against a per-period position model.
module tb_pwm_position_sequencer;

   import pwm_pkg::*;

   localparam int PER  = int'(PERIOD_CYCLES);
   localparam int HOLD = int'(HOLD_PERIODS);
   localparam int TMO  = 2 * PER;

   logic             CLK = 1'b0;
   logic             reset = 1'b0;
   logic [POS_W-1:0] pos_out;
   logic             period_start;
   logic             busy;
   logic             done;

   pwm_position_sequencer_if #(.POS_W(POS_W)) cmd_if ();

   pwm_position_sequencer #(
      .POS_W        (POS_W),
      .HOLD_PERIODS (HOLD_PERIODS)
   ) dut (
      .CLK          (CLK),
      .reset        (reset),
      .cmd          (cmd_if),
      .pos_out      (pos_out),
      .period_start (period_start),
      .busy         (busy),
      .done         (done)
   );

   always #5 CLK = ~CLK;

   int   checks = 0;
   int   errors = 0;
   int   model_pos = 0;
   int   exp_q[$];
   int   obs_pos[64];
   logic obs_busy[64];
   logic obs_done[64];
   int   obs_n;
   bit   timed_out;
   int   done_cnt;
   int   chg_mid;
   int   prev_pos;

   // Reference: list of positions seen at successive period boundaries until target is reached
   function automatic void model_path(input int from, input int to, input int step);
      int p;
      int s;
      p = from;
      s = (step == 0) ? 1 : step;
      exp_q.delete();
      while (p != to) begin
         if (p < to) p = (p + s > to) ? to : p + s;
         else        p = (p - s < to) ? to : p - s;
         exp_q.push_back(p);
      end
   endfunction

   // Record pos/busy/done at each of the next n period_start pulses
   task automatic observe(input int n);
      int waited;
      obs_n    = 0;
      prev_pos = int'(pos_out);
      for (int i = 0; i < n; i++) begin
         waited = 0;
         do begin
            @(negedge CLK);
            waited++;
            if (done === 1'b1) done_cnt++;
            if (period_start !== 1'b1 && int'(pos_out) != prev_pos) chg_mid++;
            prev_pos = int'(pos_out);
         end while (period_start !== 1'b1 && waited < TMO);
         if (period_start !== 1'b1) begin
            timed_out = 1'b1;
            return;
         end
         obs_pos[i]  = int'(pos_out);
         obs_busy[i] = busy;
         obs_done[i] = done;
         obs_n++;
      end
   endtask

   // Present one command at a negedge once ready, drop it after the accepting edge
   task automatic send_cmd(input int tpos, input int tstep);
      int waited;
      waited = 0;
      while (cmd_if.cmd_ready !== 1'b1 && waited < TMO) begin
         @(negedge CLK);
         waited++;
      end
      if (cmd_if.cmd_ready !== 1'b1) timed_out = 1'b1;
      cmd_if.cmd_pos   = POS_W'(tpos);
      cmd_if.cmd_step  = POS_W'(tstep);
      cmd_if.cmd_valid = 1'b1;
      @(negedge CLK);
      cmd_if.cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      int cycles;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_abort = 1'b0;
      cmd_if.cmd_pos   = '0;
      cmd_if.cmd_step  = '0;
      reset = 1'b0;
      repeat (3) @(negedge CLK);
      checks++;
      if (pos_out !== '0 || busy !== 1'b0 || done !== 1'b0 || period_start !== 1'b0)
         $display("FAIL reset_values pos=%0d busy=%b done=%b ps=%b, want 0 0 0 0",
                  pos_out, busy, done, period_start);
      if (pos_out !== '0 || busy !== 1'b0 || done !== 1'b0 || period_start !== 1'b0) errors++;
      reset = 1'b1;
      @(negedge CLK);
      cycles = 1;
      checks++;
      if (cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || pos_out !== '0) begin
         errors++;
         $display("FAIL after_release ready=%b busy=%b pos=%0d, want 1 0 0",
                  cmd_if.cmd_ready, busy, pos_out);
      end
      while (period_start !== 1'b1 && cycles < TMO) begin
         @(negedge CLK);
         cycles++;
      end
      checks++;
      if (cycles != PER) begin
         errors++;
         $display("FAIL first_period_start at cycle %0d, want %0d", cycles, PER);
      end
      cycles = 0;
      do begin
         @(negedge CLK);
         cycles++;
      end while (period_start !== 1'b1 && cycles < TMO);
      checks++;
      if (cycles != PER) begin
         errors++;
         $display("FAIL period_interval got %0d cycles, want %0d", cycles, PER);
      end
      model_pos = 0;
   endtask

   // One full command: ramp along the model path, hold, single done pulse, back to ready
   task automatic test_command(input string name, input int tpos, input int tstep);
      int   n_ramp;
      int   n_tot;
      int   e_pos;
      logic e_last;
      repeat ($urandom_range(800, 0)) @(negedge CLK);
      model_path(model_pos, tpos, tstep);
      n_ramp    = (exp_q.size() == 0) ? 1 : exp_q.size();
      n_tot     = n_ramp + HOLD;
      timed_out = 1'b0;
      send_cmd(tpos, tstep);
      checks++;
      if (busy !== 1'b1 || cmd_if.cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s accept busy=%b ready=%b, want 1 0", name, busy, cmd_if.cmd_ready);
      end
      done_cnt = 0;
      chg_mid  = 0;
      observe(n_tot);
      checks++;
      if (timed_out) begin
         errors++;
         $display("FAIL %s timeout saw %0d period_starts, want %0d", name, obs_n, n_tot);
      end
      for (int i = 0; i < obs_n; i++) begin
         e_pos  = (i < exp_q.size()) ? exp_q[i] : tpos;
         e_last = (i == n_tot - 1);
         checks++;
         if (obs_pos[i] != e_pos || obs_busy[i] !== ~e_last || obs_done[i] !== e_last) begin
            errors++;
            $display("FAIL %s period %0d pos=%0d busy=%b done=%b, want pos=%0d busy=%b done=%b",
                     name, i, obs_pos[i], obs_busy[i], obs_done[i], e_pos, ~e_last, e_last);
         end
      end
      @(negedge CLK);
      checks++;
      if (done !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || busy !== 1'b0 || int'(pos_out) != tpos) begin
         errors++;
         $display("FAIL %s after_done done=%b ready=%b busy=%b pos=%0d, want 0 1 0 %0d",
                  name, done, cmd_if.cmd_ready, busy, pos_out, tpos);
      end
      checks++;
      if (done_cnt != 1 || chg_mid != 0) begin
         errors++;
         $display("FAIL %s pulses done_cnt=%0d mid_period_changes=%0d, want 1 0",
                  name, done_cnt, chg_mid);
      end
      model_pos = tpos;
   endtask

   task automatic test_abort();
      timed_out = 1'b0;
      done_cnt  = 0;
      chg_mid   = 0;
      send_cmd(400, 8);
      observe(2);
      for (int i = 0; i < obs_n; i++) begin
         checks++;
         if (obs_pos[i] != 8 * (i + 1) || obs_busy[i] !== 1'b1) begin
            errors++;
            $display("FAIL abort_ramp period %0d pos=%0d busy=%b, want %0d 1",
                     i, obs_pos[i], obs_busy[i], 8 * (i + 1));
         end
      end
      // Command held while busy must not disturb the ramp
      cmd_if.cmd_pos   = '0;
      cmd_if.cmd_step  = POS_W'(1023);
      cmd_if.cmd_valid = 1'b1;
      observe(3);
      for (int i = 0; i < obs_n; i++) begin
         checks++;
         if (obs_pos[i] != 8 * (i + 3) || obs_busy[i] !== 1'b1) begin
            errors++;
            $display("FAIL abort_held_ramp period %0d pos=%0d busy=%b, want %0d 1",
                     i + 2, obs_pos[i], obs_busy[i], 8 * (i + 3));
         end
      end
      cmd_if.cmd_abort = 1'b1;
      @(negedge CLK);
      cmd_if.cmd_abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || pos_out !== POS_W'(40) || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle busy=%b ready=%b pos=%0d done=%b, want 0 1 40 0",
                  busy, cmd_if.cmd_ready, pos_out, done);
      end
      @(negedge CLK);
      cmd_if.cmd_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || cmd_if.cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL held_accept busy=%b ready=%b, want 1 0", busy, cmd_if.cmd_ready);
      end
      observe(1 + HOLD);
      checks++;
      if (timed_out || obs_n != 1 + HOLD) begin
         errors++;
         $display("FAIL abort_timeout saw %0d period_starts, want %0d", obs_n, 1 + HOLD);
      end
      checks++;
      if (obs_n > 0 && (obs_pos[0] != 0 || obs_pos[obs_n-1] != 0 || obs_done[obs_n-1] !== 1'b1)) begin
         errors++;
         $display("FAIL held_cmd first_pos=%0d last_pos=%0d last_done=%b, want 0 0 1",
                  obs_pos[0], obs_pos[obs_n-1], obs_done[obs_n-1]);
      end
      checks++;
      if (done_cnt != 1 || chg_mid != 0) begin
         errors++;
         $display("FAIL abort_pulses done_cnt=%0d mid_changes=%0d, want 1 0", done_cnt, chg_mid);
      end
      model_pos = 0;
   endtask

   task automatic test_reset_mid_ramp();
      int cycles;
      timed_out = 1'b0;
      send_cmd(400, 16);
      observe(3);
      checks++;
      if (timed_out || obs_n != 3 || obs_pos[0] != 16 || obs_pos[1] != 32 || obs_pos[2] != 48) begin
         errors++;
         $display("FAIL pre_reset_ramp n=%0d pos=%0d,%0d,%0d, want 3 16,32,48",
                  obs_n, obs_pos[0], obs_pos[1], obs_pos[2]);
      end
      repeat (100) @(negedge CLK);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (pos_out !== '0 || busy !== 1'b0 || done !== 1'b0 || period_start !== 1'b0) begin
         errors++;
         $display("FAIL async_reset pos=%0d busy=%b done=%b ps=%b, want 0 0 0 0",
                  pos_out, busy, done, period_start);
      end
      @(negedge CLK);
      reset  = 1'b1;
      cycles = 0;
      do begin
         @(negedge CLK);
         cycles++;
      end while (period_start !== 1'b1 && cycles < TMO);
      checks++;
      if (cycles != PER || pos_out !== '0 || busy !== 1'b0 || cmd_if.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL no_resume cycles=%0d pos=%0d busy=%b ready=%b, want %0d 0 0 1",
                  cycles, pos_out, busy, cmd_if.cmd_ready, PER);
      end
      // Command presented in the boundary cycle: no update on that edge
      repeat (PER - 1) @(negedge CLK);
      cmd_if.cmd_pos   = POS_W'(300);
      cmd_if.cmd_step  = POS_W'(50);
      cmd_if.cmd_valid = 1'b1;
      @(negedge CLK);
      cmd_if.cmd_valid = 1'b0;
      checks++;
      if (period_start !== 1'b1 || pos_out !== '0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL accept_in_boundary ps=%b pos=%0d busy=%b, want 1 0 1",
                  period_start, pos_out, busy);
      end
      observe(1);
      checks++;
      if (timed_out || obs_n != 1 || obs_pos[0] != 50) begin
         errors++;
         $display("FAIL first_step_late n=%0d pos=%0d, want 1 50", obs_n, obs_pos[0]);
      end
      // Abort coinciding with a boundary suppresses that step
      repeat (PER - 1) @(negedge CLK);
      cmd_if.cmd_abort = 1'b1;
      @(negedge CLK);
      cmd_if.cmd_abort = 1'b0;
      checks++;
      if (period_start !== 1'b1 || pos_out !== POS_W'(50) || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_at_boundary ps=%b pos=%0d busy=%b done=%b, want 1 50 0 0",
                  period_start, pos_out, busy, done);
      end
      model_pos = 50;
   endtask

   task automatic test_random();
      for (int k = 0; k < 2; k++) begin
         test_command("random", int'($urandom_range(1023, 0)), int'($urandom_range(1023, 342)));
      end
   endtask

   initial begin
      test_reset();
      test_abort();
      test_reset_mid_ramp();
      test_command("return_to_zero", 0, 1023);
      test_command("ramp_up", 100, 16);
      test_command("ramp_down_step0", 90, 0);
      test_command("same_target", 90, 7);
      test_command("full_jump", 1023, 1023);
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
